// File: rtl/instr_mem_banked_pkg.sv
// Shared definitions for the banked instruction memory.
//  instruction_s       : one 32-bit instruction word (RISC-V style field split)
//  instr_load_state_e  : streaming-loader states
//  bank_of / row_of    : word-interleave decode; word addr -> bank index / row in that bank
package instr_mem_banked_pkg;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instruction_s;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } instr_load_state_e;

    // fetch_width is a power of two, so these reduce to bit selects in hardware.
    function automatic int unsigned bank_of(input int unsigned addr, input int unsigned fetch_width);
        return addr % fetch_width;
    endfunction

    function automatic int unsigned row_of(input int unsigned addr, input int unsigned fetch_width);
        return addr / fetch_width;
    endfunction

endpackage

// File: rtl/instr_mem_banked_if.sv
// Load-side and fetch-side bus of the banked instruction memory.
//  master : host/fetch-stage side (drives *_i, observes *_o)
//  slave  : memory side
interface instr_mem_banked_if #(
    parameter int addr_width_p  = 10,
    parameter int fetch_width_p = 2
) ();
    import instr_mem_banked_pkg::*;

    // load side
    logic                                 load_start_i;
    logic [addr_width_p-1:0]              load_base_addr_i;
    logic                                 load_v_i;
    instruction_s                         load_data_i;
    logic                                 load_last_i;
    logic                                 load_ready_o;
    logic                                 load_busy_o;
    logic                                 load_done_o;
    logic [addr_width_p:0]                load_count_o;
    // fetch side
    logic                                 fetch_v_i;
    logic [addr_width_p-1:0]              fetch_addr_i;
    logic                                 fetch_ready_o;
    logic                                 fetch_stall_i;
    logic                                 instr_v_o;
    instruction_s [fetch_width_p-1:0]     instr_o;

    modport master (
        output load_start_i, load_base_addr_i, load_v_i, load_data_i, load_last_i,
        input  load_ready_o, load_busy_o, load_done_o, load_count_o,
        output fetch_v_i, fetch_addr_i, fetch_stall_i,
        input  fetch_ready_o, instr_v_o, instr_o
    );

    modport slave (
        input  load_start_i, load_base_addr_i, load_v_i, load_data_i, load_last_i,
        output load_ready_o, load_busy_o, load_done_o, load_count_o,
        input  fetch_v_i, fetch_addr_i, fetch_stall_i,
        output fetch_ready_o, instr_v_o, instr_o
    );

endinterface

// File: rtl/instr_mem_banked_bank.sv
// One storage bank: single port shared between write and read, write wins.
// Read data is registered and only changes on a read, so it holds between fetches.
//  clk, rst      : clock, async active-high reset (clears the read register only)
//  we/waddr/wdata: write strobe, row, data
//  re/raddr      : read strobe, row
//  rdata         : registered read data
module instr_mem_banked_bank
    import instr_mem_banked_pkg::*;
#(
    parameter int rows_p      = 512,
    parameter int row_width_p = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [row_width_p-1:0] waddr,
    input  instruction_s           wdata,
    input  logic                   re,
    input  logic [row_width_p-1:0] raddr,
    output instruction_s           rdata
);

    instruction_s           mem [rows_p];
    logic [row_width_p-1:0] addr;

    assign addr = we ? waddr : raddr;

    // Storage is never reset: contents survive a reset.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            rdata <= '0;
        else if (re && !we) rdata <= mem[addr];
    end

endmodule

// File: rtl/instr_mem_banked.sv
// Word-interleaved synchronous instruction memory with a streaming loader.
//  clk     : clock
//  reset_i : async active-high reset (memory contents kept)
//  bus     : instr_mem_banked_if.slave -- loader (start/base/v/data/last, ready/busy/done/count)
//            and fetch (v/addr/stall, ready/instr_v/instr) sides
// A fetch of fetch_width_p consecutive words at any alignment touches every bank exactly
// once; each bank reads its own row, and the bank-to-lane rotation amount is registered
// with the read so instr_o depends only on registers.
module instr_mem_banked
    import instr_mem_banked_pkg::*;
#(
    parameter int addr_width_p  = 10,
    parameter int fetch_width_p = 2
) (
    input  logic              clk,
    input  logic              reset_i,
    instr_mem_banked_if.slave bus
);

    localparam int depth_lp      = 1 << addr_width_p;
    localparam int rows_lp       = depth_lp / fetch_width_p;
    localparam int row_width_lp  = (rows_lp > 1) ? $clog2(rows_lp) : 1;
    localparam int bank_width_lp = (fetch_width_p > 1) ? $clog2(fetch_width_p) : 1;
    localparam logic [addr_width_p:0] count_max_lp = {1'b1, {addr_width_p{1'b0}}};

    instr_load_state_e                           state;
    logic [addr_width_p-1:0]                     ptr;
    logic [addr_width_p:0]                       count;
    logic                                        busy;
    logic                                        done;
    logic                                        instr_v;
    logic [bank_width_lp-1:0]                    rot;

    logic                                        accept;
    logic                                        wr_en;
    logic [row_width_lp-1:0]                     wr_row;
    logic [fetch_width_p-1:0]                    bank_we;
    logic [fetch_width_p-1:0][row_width_lp-1:0]  bank_raddr;
    instruction_s [fetch_width_p-1:0]            bank_rdata;

    assign bus.fetch_ready_o = (state == IDLE) && !(instr_v && bus.fetch_stall_i);
    assign accept            = bus.fetch_v_i && bus.fetch_ready_o;
    assign wr_en             = (state == LOAD) && bus.load_v_i;
    assign wr_row            = row_width_lp'(row_of(32'(ptr), fetch_width_p));

    assign bus.load_ready_o  = busy;
    assign bus.load_busy_o   = busy;
    assign bus.load_done_o   = done;
    assign bus.load_count_o  = count;
    assign bus.instr_v_o     = instr_v;

    // Bank b serves lane k = (b - addr) mod fetch_width_p, i.e. word addr + k.
    always_comb begin
        bank_we    = '0;
        bank_raddr = '0;
        for (int b = 0; b < fetch_width_p; b++) begin
            bank_we[b]    = wr_en && (bank_of(32'(ptr), fetch_width_p) == 32'(b));
            bank_raddr[b] = row_width_lp'(row_of(
                (32'(bus.fetch_addr_i) +
                 ((32'(b) + 32'(fetch_width_p) - bank_of(32'(bus.fetch_addr_i), fetch_width_p))
                  % 32'(fetch_width_p))) % 32'(depth_lp),
                fetch_width_p));
        end
    end

    for (genvar b = 0; b < fetch_width_p; b++) begin : g_bank
        instr_mem_banked_bank #(
            .rows_p      (rows_lp),
            .row_width_p (row_width_lp)
        ) u_bank (
            .clk   (clk),
            .rst   (reset_i),
            .we    (bank_we[b]),
            .waddr (wr_row),
            .wdata (bus.load_data_i),
            .re    (accept),
            .raddr (bank_raddr[b]),
            .rdata (bank_rdata[b])
        );
    end

    // Lane k takes the bank holding word (fetch_addr + k); rot is fetch_addr's bank.
    always_comb begin
        bus.instr_o = '0;
        for (int k = 0; k < fetch_width_p; k++) begin
            bus.instr_o[k] = bank_rdata[bank_width_lp'((32'(rot) + 32'(k)) % 32'(fetch_width_p))];
        end
    end

    // Loader FSM; busy/done are registered alongside the state.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
            ptr   <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.load_start_i) begin
                        state <= LOAD;
                        ptr   <= bus.load_base_addr_i;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.load_v_i) begin
                        ptr <= ptr + 1'b1;  // wraps at depth
                        if (count != count_max_lp) count <= count + 1'b1;
                        if (bus.load_last_i) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Output valid: set on accept, held under stall, dropped otherwise.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            instr_v <= 1'b0;
            rot     <= '0;
        end else if (accept) begin
            instr_v <= 1'b1;
            rot     <= bank_width_lp'(bank_of(32'(bus.fetch_addr_i), fetch_width_p));
        end else if (!bus.fetch_stall_i) begin
            instr_v <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_mem_banked.sv
// Bench: two memories (fetch widths 2 and 4, depth 16) driven by the same stimulus and
// checked every cycle against a word-array model, plus literal checks per scenario.
module tb_instr_mem_banked;
    import instr_mem_banked_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load_start = 1'b0;
    logic [3:0]   base = '0;
    logic         load_v = 1'b0;
    instruction_s load_data = '0;
    logic         load_last = 1'b0;
    logic         fetch_v = 1'b0;
    logic [3:0]   fetch_addr = '0;
    logic         stall = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instr_mem_banked_if #(.addr_width_p(4), .fetch_width_p(2)) ifa ();
    instr_mem_banked_if #(.addr_width_p(4), .fetch_width_p(4)) ifb ();

    assign ifa.load_start_i = load_start;  assign ifb.load_start_i = load_start;
    assign ifa.load_base_addr_i = base;     assign ifb.load_base_addr_i = base;
    assign ifa.load_v_i = load_v;           assign ifb.load_v_i = load_v;
    assign ifa.load_data_i = load_data;     assign ifb.load_data_i = load_data;
    assign ifa.load_last_i = load_last;     assign ifb.load_last_i = load_last;
    assign ifa.fetch_v_i = fetch_v;         assign ifb.fetch_v_i = fetch_v;
    assign ifa.fetch_addr_i = fetch_addr;   assign ifb.fetch_addr_i = fetch_addr;
    assign ifa.fetch_stall_i = stall;       assign ifb.fetch_stall_i = stall;

    instr_mem_banked #(.addr_width_p(4), .fetch_width_p(2)) dut_a (
        .clk(clk), .reset_i(rst), .bus(ifa));
    instr_mem_banked #(.addr_width_p(4), .fetch_width_p(4)) dut_b (
        .clk(clk), .reset_i(rst), .bus(ifb));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model: memory as a plain word array ----------------
    instruction_s mm [16];
    bit           mk [16];         // word has been written at least once
    bit           m_load = 0, m_done = 0, m_iv = 0;
    int           m_ptr = 0, m_count = 0;
    instruction_s m_instr [4] = '{default: '0};
    bit           m_ik [4] = '{default: 1'b1};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_load = 0; m_done = 0; m_count = 0; m_iv = 0;
            for (int k = 0; k < 4; k++) begin m_instr[k] = '0; m_ik[k] = 1; end
        end else begin
            if (!m_load && !m_done && fetch_v && !(m_iv && stall)) begin
                m_iv = 1;
                for (int k = 0; k < 4; k++) begin
                    m_instr[k] = mm[(int'(fetch_addr) + k) % 16];
                    m_ik[k]    = mk[(int'(fetch_addr) + k) % 16];
                end
            end else if (!stall) begin
                m_iv = 0;
            end
            if (m_done) m_done = 0;
            else if (m_load) begin
                if (load_v) begin
                    mm[m_ptr] = load_data;
                    mk[m_ptr] = 1;
                    m_ptr     = (m_ptr + 1) % 16;
                    m_count   = (m_count < 16) ? m_count + 1 : 16;
                    if (load_last) begin m_load = 0; m_done = 1; end
                end
            end else if (load_start) begin
                m_load = 1; m_ptr = int'(base); m_count = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("a.instr_v", ifa.instr_v_o, m_iv);
        chk("b.instr_v", ifb.instr_v_o, m_iv);
        chk("a.load_ready", ifa.load_ready_o, m_load);
        chk("a.load_busy", ifa.load_busy_o, m_load);
        chk("b.load_busy", ifb.load_busy_o, m_load);
        chk("a.load_done", ifa.load_done_o, m_done);
        chk("b.load_done", ifb.load_done_o, m_done);
        chk("a.load_count", ifa.load_count_o, m_count);
        chk("b.load_count", ifb.load_count_o, m_count);
        chk("a.fetch_ready", ifa.fetch_ready_o, !m_load && !m_done && !(m_iv && stall));
        chk("b.fetch_ready", ifb.fetch_ready_o, !m_load && !m_done && !(m_iv && stall));
        for (int k = 0; k < 2; k++) if (m_ik[k]) chk($sformatf("a.instr[%0d]", k), ifa.instr_o[k], m_instr[k]);
        for (int k = 0; k < 4; k++) if (m_ik[k]) chk($sformatf("b.instr[%0d]", k), ifb.instr_o[k], m_instr[k]);
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int a);
        fetch_v = 1'b1;
        fetch_addr = 4'(a);
        cyc();
        fetch_v = 1'b0;
    endtask

    task automatic load(input int b, input int n, input int first);
        load_start = 1'b1;
        base = 4'(b);
        cyc();
        load_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            load_v = 1'b1;
            load_data = instruction_s'(32'(first + i));
            load_last = (i == n - 1);
            cyc();
        end
        load_v = 1'b0;
        load_last = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        chk("reset count", ifa.load_count_o, 0);
        chk("reset instr", {ifa.instr_o[1], ifa.instr_o[0]}, 64'h0);

        // 1: reset in the middle of a load keeps the written words
        load_start = 1'b1; base = 4'd0;
        cyc();
        load_start = 1'b0;
        chk("s1 ready in load", ifa.load_ready_o, 1);
        for (int i = 0; i < 3; i++) begin
            load_v = 1'b1; load_data = instruction_s'(32'h200 + 32'(i)); cyc();
        end
        load_v = 1'b0;
        chk("s1 count 3", ifa.load_count_o, 3);
        rst = 1'b1;
        #1;
        chk("s1 reset count", ifa.load_count_o, 0);
        chk("s1 reset ready", ifa.load_ready_o, 0);
        cyc();
        rst = 1'b0;
        fetch(0);
        chk("s1 fetch@0", {ifa.instr_o[1], ifa.instr_o[0]}, 64'h00000201_00000200);
        chk("s1 instr_v", ifa.instr_v_o, 1);

        // 2: full load, done pulse, aligned fetch
        load(0, 16, 32'h100);
        chk("s2 done", ifa.load_done_o, 1);
        chk("s2 count 16", ifa.load_count_o, 16);
        cyc();
        chk("s2 done cleared", ifa.load_done_o, 0);
        fetch(4);
        chk("s2 fetch@4", {ifa.instr_o[1], ifa.instr_o[0]}, 64'h00000105_00000104);

        // 3: unaligned and wrapping fetch
        fetch(5);
        chk("s3 fetch@5", {ifa.instr_o[1], ifa.instr_o[0]}, 64'h00000106_00000105);
        fetch(15);
        chk("s3 fetch@15", {ifa.instr_o[1], ifa.instr_o[0]}, 64'h00000100_0000010F);
        chk("s3 w4 fetch@15 lo", {ifb.instr_o[1], ifb.instr_o[0]}, 64'h00000100_0000010F);
        chk("s3 w4 fetch@15 hi", {ifb.instr_o[3], ifb.instr_o[2]}, 64'h00000102_00000101);
        cyc();

        // 4: load pointer wraps
        load(14, 4, 32'hAAA);  // words AAA,AAB,AAC,AAD
        chk("s4 count 4", ifa.load_count_o, 4);
        cyc();
        fetch(14);
        chk("s4 fetch@14", {ifa.instr_o[1], ifa.instr_o[0]}, 64'h00000AAB_00000AAA);
        fetch(0);
        chk("s4 fetch@0", {ifa.instr_o[1], ifa.instr_o[0]}, 64'h00000AAD_00000AAC);

        // 5: stall holds outputs and blocks fetch
        fetch_v = 1'b1; fetch_addr = 4'd2;
        cyc();
        stall = 1'b1; fetch_addr = 4'd8;
        #1;
        chk("s5 ready stalled", ifa.fetch_ready_o, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("s5 held", {ifa.instr_o[1], ifa.instr_o[0]}, 64'h00000103_00000102);
            chk("s5 held v", ifa.instr_v_o, 1);
        end
        stall = 1'b0;
        #1;
        chk("s5 ready released", ifa.fetch_ready_o, 1);
        cyc();
        fetch_v = 1'b0;
        chk("s5 fetch@8", {ifa.instr_o[1], ifa.instr_o[0]}, 64'h00000109_00000108);

        // 6: fetch and load start collide
        fetch_v = 1'b1; fetch_addr = 4'd6;
        load_start = 1'b1; base = 4'd0;
        cyc();
        load_start = 1'b0; fetch_addr = 4'd0;
        chk("s6 fetch@6", {ifa.instr_o[1], ifa.instr_o[0]}, 64'h00000107_00000106);
        chk("s6 busy", ifa.load_busy_o, 1);
        chk("s6 ready blocked", ifa.fetch_ready_o, 0);
        load_v = 1'b1; load_data = instruction_s'(32'h300);
        cyc();
        load_data = instruction_s'(32'h301); load_last = 1'b1;
        cyc();
        load_v = 1'b0; load_last = 1'b0;
        chk("s6 done", ifa.load_done_o, 1);
        chk("s6 ready in done", ifa.fetch_ready_o, 0);
        cyc();
        chk("s6 ready idle", ifa.fetch_ready_o, 1);
        cyc();
        fetch_v = 1'b0;
        chk("s6 fetch@0", {ifa.instr_o[1], ifa.instr_o[0]}, 64'h00000301_00000300);
        chk("s6 w4 fetch@0 hi", {ifb.instr_o[3], ifb.instr_o[2]}, 64'h00000103_00000102);

        // count saturates; 17th word overwrites the first
        load(3, 17, 32'h400);
        chk("sat count 16", ifa.load_count_o, 16);
        cyc();
        fetch(3);
        chk("sat fetch@3", {ifa.instr_o[1], ifa.instr_o[0]}, 64'h00000401_00000410);
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
